pmipsl_fetch_unit: RTL and testbench
====================================

Name: pmipsl_fetch_unit

Overview:
Parametrised instruction-fetch stage for the next PMIPS-Lite pipeline generation. It replaces the bare PC register and IF/ID latch with three pieces:
- a fetch engine that supports variable instruction-memory latency;
- a small prefetch buffer;
- a valid/ready handshake into decode.
Branch and jump redirects from later stages flush the buffer and cancel any in-flight fetch.

Parameters:
ADDR_W, 16, PC and instruction-memory address width
INSTR_W, 17, instruction word width
DEPTH, 4, prefetch buffer entries (power of 2, >= 2)
PC_STEP, 2, byte increment per instruction
RESET_PC, 0, fetch address after reset

Ports:
clock  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
imemreq  output  1  single-cycle fetch request pulse
imemaddr  output  ADDR_W  fetch address; valid when imemreq=1
imemack  input  1  response strobe; arrives at least 1 cycle after imemreq
imemrdata  input  INSTR_W  instruction data; valid when imemack=1
redirect  input  1  branch/jump taken; load redirectaddr
redirectaddr  input  ADDR_W  new fetch PC; used as-is, no alignment
idready  input  1  decode stage can accept an instruction
idvalid  output  1  buffer head valid
idinstr  output  INSTR_W  head instruction
idpcplus  output  ADDR_W  head PC + PC_STEP
count  output  $clog2(DEPTH+1)  buffer occupancy

Behaviour:
- Reset (sampled on clock edge):
  - imemreq=0, imemaddr=RESET_PC, fetchpc=RESET_PC, state=IDLE.
  - Buffer empty: idvalid=0, idinstr=0, idpcplus=0, count=0.
  - Reset overrides redirect and imemack in the same cycle; a stale ack after reset is ignored because state is IDLE.
- Protocol and sizing:
  - At most one outstanding request.
  - imemaddr always equals fetchpc.
  - fetchpc arithmetic wraps modulo 2^ADDR_W.
- FSM states: IDLE (nothing outstanding), WAIT (valid request outstanding), DISCARD (stale request outstanding).
- IDLE:
  - redirect=1: fetchpc<=redirectaddr; flush buffer; no request this cycle.
  - Otherwise, if count<DEPTH: imemreq=1 (combinational) and go to WAIT.
  - imemack in IDLE is ignored.
- WAIT:
  - imemack=1 and redirect=0: push {imemrdata, fetchpc+PC_STEP}; fetchpc<=fetchpc+PC_STEP; go to IDLE.
  - redirect=1 and imemack=1: drop the data; flush buffer; fetchpc<=redirectaddr; go to IDLE.
  - redirect=1 and imemack=0: flush buffer; fetchpc<=redirectaddr; go to DISCARD.
- DISCARD:
  - imemack=1: drop the data; go to IDLE.
  - redirect=1: fetchpc<=redirectaddr; stay in DISCARD unless imemack=1 in the same cycle (then go to IDLE).
  - Buffer is not written.
- Buffer:
  - Show-ahead sync FIFO: idvalid = (count != 0); idinstr/idpcplus come from the head entry.
  - Pop on idvalid & idready.
  - Push and pop in the same cycle leave count unchanged.
  - Push while full cannot occur, because a request is issued only when count<DEPTH and a single request is outstanding.
- Flush priority:
  - Flush overrides pop and push in the same cycle; count=0 and idvalid=0 on the next cycle.
  - idready is a don't-care during a flush cycle.
- Latency:
  - Earliest request is the first cycle after reset deasserts.
  - A zero-stall ack returns 1 cycle after the request.
  - Data appears on idvalid the cycle after the ack.
  - Sustained throughput is one instruction per 2 cycles with 1-cycle memory, since the engine alternates IDLE and WAIT.
- Redirect to the same address as current fetchpc is still honoured: flush and discard.

Decomposition:
- Shared package pmipsl_pkg holds:
  - fetch_state_t enum {IDLE, WAIT, DISCARD};
  - PMIPSL_ADDR_W=16, PMIPSL_INSTR_W=17, PMIPSL_PC_STEP=2.
- Sub-module pmipsl_fifo: parametrised show-ahead sync FIFO with push, pop, flush and count. It is reusable for later data-side buffering.
- FSM, fetchpc and request logic stay in pmipsl_fetch_unit.

Test Plan:
1. Reset, then 1-cycle ack memory returning imemrdata=addr-tagged words, idready=1 -> imemaddr sequence 0,2,4,6; idvalid first high 2 cycles after the first req; idpcplus 2,4,6.
2. idready=0 held -> exactly 4 requests issued (0,2,4,6), count=4, imemreq stays 0; raise idready -> pops 0,2,4,6 in order and fetch resumes at 8.
3. Request at addr 4 outstanding, redirect=1 with redirectaddr=0x0100 and no ack -> buffer flushed next cycle, state DISCARD; the next ack is dropped; following imemreq has imemaddr=0x0100.
4. redirect coincident with imemack in WAIT -> returned word never appears on idinstr; next request to redirectaddr issued the following cycle.
5. RESET_PC=0xFFFE, PC_STEP=2 -> second fetch address is 0x0000 (wrap); idpcplus of the first instruction is 0x0000.
6. reset asserted while in WAIT with count=3 -> next cycle count=0, idvalid=0, imemaddr=RESET_PC; a late ack arriving afterwards is ignored.

Source files
------------

// File: rtl/pmipsl_pkg.sv
// Shared types and default widths for the PMIPS-Lite pipeline.
// Fetch-engine state encoding lives here so later stages can decode it.
package pmipsl_pkg;

  localparam int unsigned PMIPSL_ADDR_W  = 16;
  localparam int unsigned PMIPSL_INSTR_W = 17;
  localparam int unsigned PMIPSL_PC_STEP = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/pmipsl_fifo.sv
// Show-ahead synchronous FIFO with push, pop, flush and occupancy count.
// The head entry is presented combinationally; the output is zero when empty.
module pmipsl_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         push,
  input  logic [WIDTH-1:0]             pushData,
  input  logic                         pop,
  output logic [WIDTH-1:0]             popData,
  output logic                         valid,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W-1:0] wrPtr;
  logic [CNT_W-1:0] countQ;
  logic             doPush;
  logic             doPop;
  logic             clear;

  assign clear  = reset || flush;
  assign doPush = push;
  assign doPop  = pop && (countQ != '0);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (clear) begin
      rdPtr  <= '0;
      wrPtr  <= '0;
      countQ <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      if (doPush && !doPop) begin
        countQ <= countQ + 1'b1;
      end else if (!doPush && doPop) begin
        countQ <= countQ - 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (doPush && !clear) begin
      mem[wrPtr] <= pushData;
    end
  end

  assign valid   = (countQ != '0);
  assign popData = valid ? mem[rdPtr] : '0;
  assign count   = countQ;

endmodule

// File: rtl/pmipsl_fetch_unit.sv
// Instruction fetch stage: single-outstanding fetch engine feeding a prefetch
// buffer, with redirects flushing the buffer and cancelling in-flight fetches.
module pmipsl_fetch_unit
  import pmipsl_pkg::*;
#(
  parameter int unsigned     ADDR_W   = PMIPSL_ADDR_W,
  parameter int unsigned     INSTR_W  = PMIPSL_INSTR_W,
  parameter int unsigned     DEPTH    = 4,
  parameter int unsigned     PC_STEP  = PMIPSL_PC_STEP,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                         clock,
  input  logic                         reset,
  output logic                         imemreq,
  output logic [ADDR_W-1:0]            imemaddr,
  input  logic                         imemack,
  input  logic [INSTR_W-1:0]           imemrdata,
  input  logic                         redirect,
  input  logic [ADDR_W-1:0]            redirectaddr,
  input  logic                         idready,
  output logic                         idvalid,
  output logic [INSTR_W-1:0]           idinstr,
  output logic [ADDR_W-1:0]            idpcplus,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  fetch_state_t        state;
  fetch_state_t        stateNext;
  logic [ADDR_W-1:0]   fetchPc;
  logic [ADDR_W-1:0]   fetchPcNext;
  logic [ADDR_W-1:0]   pcPlus;
  logic                canFetch;
  logic                push;
  logic                flush;
  logic                pop;

  assign pcPlus   = fetchPc + ADDR_W'(PC_STEP);
  assign canFetch = (count < CNT_W'(DEPTH));
  assign imemaddr = fetchPc;
  assign pop      = idvalid && idready;

  always_comb begin
    stateNext   = state;
    fetchPcNext = fetchPc;
    imemreq     = 1'b0;
    push        = 1'b0;
    flush       = 1'b0;
    unique case (state)
      IDLE: begin
        if (redirect) begin
          fetchPcNext = redirectaddr;
          flush       = 1'b1;
        end else if (canFetch) begin
          imemreq   = 1'b1;
          stateNext = WAIT;
        end
      end
      WAIT: begin
        if (redirect) begin
          // A late response to the old stream must be swallowed in DISCARD.
          flush       = 1'b1;
          fetchPcNext = redirectaddr;
          stateNext   = imemack ? IDLE : DISCARD;
        end else if (imemack) begin
          push        = 1'b1;
          fetchPcNext = pcPlus;
          stateNext   = IDLE;
        end
      end
      DISCARD: begin
        if (redirect) begin
          fetchPcNext = redirectaddr;
          flush       = 1'b1;
        end
        if (imemack) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
    if (reset) begin
      imemreq = 1'b0;
      push    = 1'b0;
      flush   = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      fetchPc <= RESET_PC;
    end else begin
      state   <= stateNext;
      fetchPc <= fetchPcNext;
    end
  end

  pmipsl_fifo #(
    .WIDTH (INSTR_W + ADDR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .flush    (flush),
    .push     (push),
    .pushData ({imemrdata, pcPlus}),
    .pop      (pop),
    .popData  ({idinstr, idpcplus}),
    .valid    (idvalid),
    .count    (count)
  );

endmodule

// File: tb/tb_pmipsl_fetch_unit.sv
// Self-checking bench for pmipsl_fetch_unit: directed scenarios plus a
// randomized run scored against a queue-based model of the fetch stream.
module tb_pmipsl_fetch_unit;

  localparam int DEPTH = 4;

  typedef struct {
    logic [16:0] instr;
    logic [15:0] pc;
  } ent_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        imemreq;
  logic [15:0] imemaddr;
  logic        imemack;
  logic [16:0] imemrdata;
  logic        redirect = 1'b0;
  logic [15:0] redirectaddr = '0;
  logic        idready = 1'b0;
  logic        idvalid;
  logic [16:0] idinstr;
  logic [15:0] idpcplus;
  logic [2:0]  count;

  logic        imemreq2;
  logic [15:0] imemaddr2;
  logic        ack2 = 1'b0;
  logic [16:0] rdata2 = '0;
  logic        idvalid2;
  logic [16:0] idinstr2;
  logic [15:0] idpcplus2;
  logic [2:0]  count2;

  int checks = 0;
  int errors = 0;

  bit          memAuto = 1'b0;
  int unsigned maxLat = 0;
  int unsigned nextLat = 0;
  logic        autoAck = 1'b0;
  logic [16:0] autoData = '0;
  logic        manAck = 1'b0;
  logic [16:0] manData = '0;
  logic        pend = 1'b0;
  logic [15:0] pAddr = '0;
  int unsigned cnt = 0;

  always #5 clock = ~clock;

  assign imemack   = autoAck | manAck;
  assign imemrdata = autoAck ? autoData : manData;

  function automatic logic [16:0] tagOf(input logic [15:0] a);
    return {1'b1, a ^ 16'h5A5A};
  endfunction

  pmipsl_fetch_unit dut (
    .clock        (clock),
    .reset        (reset),
    .imemreq      (imemreq),
    .imemaddr     (imemaddr),
    .imemack      (imemack),
    .imemrdata    (imemrdata),
    .redirect     (redirect),
    .redirectaddr (redirectaddr),
    .idready      (idready),
    .idvalid      (idvalid),
    .idinstr      (idinstr),
    .idpcplus     (idpcplus),
    .count        (count)
  );

  pmipsl_fetch_unit #(
    .RESET_PC (16'hFFFE)
  ) dutWrap (
    .clock        (clock),
    .reset        (reset),
    .imemreq      (imemreq2),
    .imemaddr     (imemaddr2),
    .imemack      (ack2),
    .imemrdata    (rdata2),
    .redirect     (redirect),
    .redirectaddr (redirectaddr),
    .idready      (idready),
    .idvalid      (idvalid2),
    .idinstr      (idinstr2),
    .idpcplus     (idpcplus2),
    .count        (count2)
  );

  // Random-latency memory for the main DUT (latency 0 = ack next cycle).
  always @(posedge clock) begin
    nextLat <= $urandom_range(maxLat, 0);
    autoAck <= 1'b0;
    if (reset || !memAuto) begin
      pend <= 1'b0;
    end else if (pend) begin
      if (cnt == 0) begin
        autoAck  <= 1'b1;
        autoData <= tagOf(pAddr);
        pend     <= 1'b0;
      end else begin
        cnt <= cnt - 1;
      end
    end else if (imemreq) begin
      if (nextLat == 0) begin
        autoAck  <= 1'b1;
        autoData <= tagOf(imemaddr);
      end else begin
        pend  <= 1'b1;
        pAddr <= imemaddr;
        cnt   <= nextLat - 1;
      end
    end
  end

  always @(posedge clock) begin
    ack2   <= imemreq2 && !reset;
    rdata2 <= tagOf(imemaddr2);
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic doReset();
    reset    = 1'b1;
    redirect = 1'b0;
    manAck   = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic waitReq(output logic [15:0] a);
    for (int i = 0; i < 12 && !imemreq; i++) tick();
    checks++;
    if (!imemreq) begin
      errors++;
      $display("FAIL req_timeout got imemreq=%0b want 1", imemreq);
    end
    a = imemaddr;
  endtask

  task automatic manualFetch(input logic [15:0] want);
    logic [15:0] a;
    waitReq(a);
    checks++;
    if (a !== want) begin errors++; $display("FAIL fetch_addr got %h want %h", a, want); end
    tick();
    manAck  = 1'b1;
    manData = tagOf(a);
    tick();
    manAck = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    memAuto = 1'b0;
    reset   = 1'b1;
    repeat (2) tick();
    checks += 7;
    if (imemreq !== 1'b0) begin errors++; $display("FAIL rst_req got %b want 0", imemreq); end
    if (imemaddr !== 16'h0) begin errors++; $display("FAIL rst_addr got %h want 0", imemaddr); end
    if (idvalid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", idvalid); end
    if (idinstr !== 17'h0) begin errors++; $display("FAIL rst_instr got %h want 0", idinstr); end
    if (idpcplus !== 16'h0) begin errors++; $display("FAIL rst_pcplus got %h want 0", idpcplus); end
    if (count !== 3'd0) begin errors++; $display("FAIL rst_count got %0d want 0", count); end
    if (imemaddr2 !== 16'hFFFE || count2 !== 3'd0) begin
      errors++; $display("FAIL rst_wrap got %h/%0d want fffe/0", imemaddr2, count2);
    end
  endtask

  task automatic test_stream();
    int nreq = 0, npc = 0, firstReq = -1, firstVal = -1;
    logic [15:0] reqA [4];
    logic [15:0] pcs [3];
    memAuto = 1'b1;
    maxLat  = 0;
    doReset();
    idready = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (imemreq) begin
        if (nreq < 4) reqA[nreq] = imemaddr;
        if (nreq == 0) firstReq = cyc;
        nreq++;
      end
      if (idvalid) begin
        if (firstVal < 0) firstVal = cyc;
        if (npc < 3) pcs[npc] = idpcplus;
        npc++;
      end
      tick();
    end
    checks += 2;
    if (firstReq != 0) begin errors++; $display("FAIL st_first_req got %0d want 0", firstReq); end
    if (firstVal != 2) begin errors++; $display("FAIL st_first_valid got %0d want 2", firstVal); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (nreq <= i || reqA[i] !== 16'(2 * i)) begin
        errors++; $display("FAIL st_addr%0d got %h want %h", i, reqA[i], 16'(2 * i));
      end
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (npc <= i || pcs[i] !== 16'(2 * i + 2)) begin
        errors++; $display("FAIL st_pcplus%0d got %h want %h", i, pcs[i], 16'(2 * i + 2));
      end
    end
  endtask

  task automatic test_backpressure();
    int nreq = 0, npop = 0;
    logic [15:0] reqA [4];
    logic [15:0] pcs [4];
    logic [16:0] ins [4];
    logic [15:0] resume = 16'hDEAD;
    bit resumed = 1'b0;
    memAuto = 1'b1;
    maxLat  = 0;
    idready = 1'b0;
    doReset();
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (imemreq) begin
        if (nreq < 4) reqA[nreq] = imemaddr;
        nreq++;
      end
      tick();
    end
    checks += 3;
    if (nreq != 4) begin errors++; $display("FAIL bp_nreq got %0d want 4", nreq); end
    if (count !== 3'd4) begin errors++; $display("FAIL bp_count got %0d want 4", count); end
    if (imemreq !== 1'b0) begin errors++; $display("FAIL bp_req got %b want 0", imemreq); end
    for (int i = 0; i < 4 && i < nreq; i++) begin
      checks++;
      if (reqA[i] !== 16'(2 * i)) begin
        errors++; $display("FAIL bp_addr%0d got %h want %h", i, reqA[i], 16'(2 * i));
      end
    end
    idready = 1'b1;
    #1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (idvalid && npop < 4) begin
        pcs[npop] = idpcplus;
        ins[npop] = idinstr;
        npop++;
      end
      if (imemreq && !resumed) begin
        resume  = imemaddr;
        resumed = 1'b1;
      end
      tick();
    end
    idready = 1'b0;
    checks++;
    if (resume !== 16'h0008) begin errors++; $display("FAIL bp_resume got %h want 0008", resume); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (npop <= i || pcs[i] !== 16'(2 * i + 2) || ins[i] !== tagOf(16'(2 * i))) begin
        errors++;
        $display("FAIL bp_pop%0d got %h/%h want %h/%h", i, pcs[i], ins[i],
                 16'(2 * i + 2), tagOf(16'(2 * i)));
      end
    end
  endtask

  task automatic test_redirect_discard();
    logic [15:0] a;
    memAuto = 1'b0;
    idready = 1'b0;
    doReset();
    manualFetch(16'h0000);
    manualFetch(16'h0002);
    waitReq(a);
    checks++;
    if (a !== 16'h0004) begin errors++; $display("FAIL rd_addr got %h want 0004", a); end
    tick();
    redirect     = 1'b1;
    redirectaddr = 16'h0100;
    tick();
    redirect = 1'b0;
    #1;
    checks += 3;
    if (count !== 3'd0) begin errors++; $display("FAIL rd_flush_count got %0d want 0", count); end
    if (idvalid !== 1'b0) begin errors++; $display("FAIL rd_flush_valid got %b want 0", idvalid); end
    if (imemreq !== 1'b0) begin errors++; $display("FAIL rd_discard_req got %b want 0", imemreq); end
    repeat (2) tick();
    checks++;
    if (imemreq !== 1'b0) begin errors++; $display("FAIL rd_discard_hold got %b want 0", imemreq); end
    manAck  = 1'b1;
    manData = tagOf(16'h0004);
    tick();
    manAck = 1'b0;
    #1;
    checks += 3;
    if (count !== 3'd0) begin errors++; $display("FAIL rd_dropped got %0d want 0", count); end
    if (imemreq !== 1'b1) begin errors++; $display("FAIL rd_newreq got %b want 1", imemreq); end
    if (imemaddr !== 16'h0100) begin errors++; $display("FAIL rd_newaddr got %h want 0100", imemaddr); end
  endtask

  task automatic test_redirect_ack();
    logic [15:0] a;
    memAuto = 1'b0;
    doReset();
    idready = 1'b1;
    waitReq(a);
    tick();
    manAck       = 1'b1;
    manData      = 17'h1ABCD;
    redirect     = 1'b1;
    redirectaddr = 16'h0200;
    tick();
    manAck   = 1'b0;
    redirect = 1'b0;
    #1;
    checks += 3;
    if (idvalid !== 1'b0 || count !== 3'd0) begin
      errors++; $display("FAIL ra_dropped got %b/%0d want 0/0", idvalid, count);
    end
    if (imemreq !== 1'b1) begin errors++; $display("FAIL ra_req got %b want 1", imemreq); end
    if (imemaddr !== 16'h0200) begin errors++; $display("FAIL ra_addr got %h want 0200", imemaddr); end
    tick();
    manAck  = 1'b1;
    manData = tagOf(16'h0200);
    tick();
    manAck = 1'b0;
    #1;
    checks += 2;
    if (idvalid !== 1'b1 || idinstr !== tagOf(16'h0200)) begin
      errors++; $display("FAIL ra_instr got %b/%h want 1/%h", idvalid, idinstr, tagOf(16'h0200));
    end
    if (idpcplus !== 16'h0202) begin errors++; $display("FAIL ra_pcplus got %h want 0202", idpcplus); end
  endtask

  task automatic test_wrap();
    int nreq = 0;
    logic [15:0] reqA [2];
    logic [15:0] firstPc = 16'hDEAD;
    logic [16:0] firstIns = '0;
    bit seen = 1'b0;
    doReset();
    idready = 1'b1;
    for (int cyc = 0; cyc < 8; cyc++) begin
      if (imemreq2) begin
        if (nreq < 2) reqA[nreq] = imemaddr2;
        nreq++;
      end
      if (idvalid2 && !seen) begin
        firstPc  = idpcplus2;
        firstIns = idinstr2;
        seen     = 1'b1;
      end
      tick();
    end
    checks += 3;
    if (nreq < 2 || reqA[0] !== 16'hFFFE) begin errors++; $display("FAIL wr_addr0 got %h want fffe", reqA[0]); end
    if (nreq < 2 || reqA[1] !== 16'h0000) begin errors++; $display("FAIL wr_addr1 got %h want 0000", reqA[1]); end
    if (firstPc !== 16'h0000 || firstIns !== tagOf(16'hFFFE)) begin
      errors++; $display("FAIL wr_pcplus got %h/%h want 0000/%h", firstPc, firstIns, tagOf(16'hFFFE));
    end
  endtask

  task automatic test_reset_in_wait();
    logic [15:0] a;
    memAuto = 1'b0;
    idready = 1'b0;
    doReset();
    manualFetch(16'h0000);
    manualFetch(16'h0002);
    manualFetch(16'h0004);
    waitReq(a);
    tick();
    checks++;
    if (count !== 3'd3) begin errors++; $display("FAIL rw_pre_count got %0d want 3", count); end
    reset = 1'b1;
    tick();
    checks += 2;
    if (count !== 3'd0 || idvalid !== 1'b0) begin
      errors++; $display("FAIL rw_count got %0d/%b want 0/0", count, idvalid);
    end
    if (imemaddr !== 16'h0000 || imemreq !== 1'b0) begin
      errors++; $display("FAIL rw_addr got %h/%b want 0000/0", imemaddr, imemreq);
    end
    reset   = 1'b0;
    manAck  = 1'b1;
    manData = 17'h1DEAD;
    tick();
    manAck = 1'b0;
    #1;
    checks++;
    if (count !== 3'd0) begin errors++; $display("FAIL rw_stale got %0d want 0", count); end
    manAck  = 1'b1;
    manData = tagOf(16'h0000);
    tick();
    manAck = 1'b0;
    #1;
    checks++;
    if (count !== 3'd1 || idinstr !== tagOf(16'h0000) || idpcplus !== 16'h0002) begin
      errors++; $display("FAIL rw_refetch got %0d/%h/%h want 1/%h/0002", count, idinstr, idpcplus,
                         tagOf(16'h0000));
    end
  endtask

  task automatic test_random();
    ent_t q[$];
    ent_t e;
    logic [15:0] expPc = 16'h0000;
    bit outstanding = 1'b0;
    bit reqValid = 1'b0;
    bit newReq;
    int nReqs = 0;
    memAuto = 1'b1;
    maxLat  = 3;
    doReset();
    for (int cyc = 0; cyc < 1500 && errors < 20; cyc++) begin
      redirect     = ($urandom_range(19, 0) == 0);
      redirectaddr = 16'($urandom);
      idready      = ($urandom_range(9, 0) < 7);
      #1;
      checks += 2;
      if (count !== 3'(q.size())) begin
        errors++; $display("FAIL rnd_count got %0d want %0d", count, q.size());
      end
      if (idvalid !== (q.size() != 0)) begin
        errors++; $display("FAIL rnd_valid got %b want %b", idvalid, q.size() != 0);
      end
      if (q.size() != 0) begin
        checks++;
        if (idinstr !== q[0].instr || idpcplus !== q[0].pc) begin
          errors++; $display("FAIL rnd_head got %h/%h want %h/%h", idinstr, idpcplus, q[0].instr, q[0].pc);
        end
      end
      newReq = imemreq;
      if (imemreq) begin
        checks++;
        nReqs++;
        if (imemaddr !== expPc || outstanding || q.size() >= DEPTH) begin
          errors++; $display("FAIL rnd_req got %h want %h (outstanding=%0b size=%0d)", imemaddr, expPc,
                             outstanding, q.size());
        end
      end
      if (!redirect && q.size() != 0 && idready) void'(q.pop_front());
      if (imemack) begin
        if (reqValid && !redirect) begin
          e.instr = tagOf(expPc);
          e.pc    = expPc + 16'd2;
          q.push_back(e);
          expPc = expPc + 16'd2;
        end
        outstanding = 1'b0;
      end
      if (redirect) begin
        q.delete();
        expPc    = redirectaddr;
        reqValid = 1'b0;
      end
      if (newReq) begin
        outstanding = 1'b1;
        reqValid    = 1'b1;
      end
      tick();
    end
    redirect = 1'b0;
    checks++;
    if (nReqs < 100) begin errors++; $display("FAIL rnd_progress got %0d want >=100", nReqs); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_discard();
    test_redirect_ack();
    test_wrap();
    test_reset_in_wait();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
